// File: rtl/multi_coupling_estimator.sv
`default_nettype none
// ============================================================================
//  Module   : multi_coupling_estimator
//  Purpose  : Streams up to MAX_NBR (phase, J) coupling beats for one spin and
//             accumulates saturating sums of J*sin(d) and J*cos(d), where
//             d = self_phase - coupling_phase (mod 2^PHASE_W).
//  Revision : 1.0 - initial release
// ============================================================================
module multi_coupling_estimator #(
  parameter int PHASE_W = 8,
  parameter int NL_W    = 12,
  parameter int COUP_W  = 8,
  parameter int MAX_NBR = 16,
  parameter int ACC_W   = 28,
  parameter int CNT_W   = $clog2(MAX_NBR + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_nbr,
  input  logic [PHASE_W-1:0]       self_phase,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PHASE_W-1:0]       coupling_phase,
  input  logic signed [COUP_W-1:0] coupling_factor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_gradient,
  output logic signed [ACC_W-1:0]  out_hamiltonian,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam int LUT_N  = 2 ** PHASE_W;
  localparam int AMP    = (2 ** (NL_W - 1)) - 1;
  localparam int PROD_W = COUP_W + NL_W;
  // Wide enough that neither the accumulator nor a single product can wrap
  // before the clamp is applied (matters when ACC_W is narrower than PROD_W).
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX =
    signed'({{(SUM_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN =
    signed'({{(SUM_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}});
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NBR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Elaboration-time table entry: rounded (half away from zero) scaled sine/cosine.
  function automatic logic signed [NL_W-1:0] lut_val(input int idx, input bit is_cos);
    real ang;
    real v;
    real r;
    ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(LUT_N);
    v   = (is_cos ? $cos(ang) : $sin(ang)) * real'(AMP);
    r   = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    return NL_W'($rtoi(r));
  endfunction

  // Adds a product to an accumulator, clamping to the ACC_W signed range.
  // Bit ACC_W of the result flags that a clamp occurred.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0]  acc,
                                             input logic signed [PROD_W-1:0] prod);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(prod);
    if (sum > ACC_MAX)      return {1'b1, ACC_MAX[ACC_W-1:0]};
    else if (sum < ACC_MIN) return {1'b1, ACC_MIN[ACC_W-1:0]};
    else                    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  logic signed [NL_W-1:0] sin_lut [LUT_N];
  logic signed [NL_W-1:0] cos_lut [LUT_N];

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      assign sin_lut[gi] = lut_val(gi, 1'b0);
      assign cos_lut[gi] = lut_val(gi, 1'b1);
    end
  endgenerate

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        self_q;
  logic [CNT_W-1:0]          num_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      s1_valid_q;
  logic [PHASE_W-1:0]        s1_delta_q;
  logic signed [COUP_W-1:0]  s1_j_q;
  logic                      s2_valid_q;
  logic signed [NL_W-1:0]    s2_sin_q;
  logic signed [NL_W-1:0]    s2_cos_q;
  logic signed [COUP_W-1:0]  s2_j_q;
  logic signed [ACC_W-1:0]   grad_q;
  logic signed [ACC_W-1:0]   ham_q;
  logic                      sat_q;

  logic [CNT_W-1:0]          num_clamped;
  logic                      start_ok;
  logic                      ready_int;
  logic                      accept;
  logic signed [PROD_W-1:0]  grad_prod;
  logic signed [PROD_W-1:0]  ham_prod;
  logic [ACC_W:0]            grad_sum;
  logic [ACC_W:0]            ham_sum;

  assign num_clamped = (num_nbr > MAX_CNT) ? MAX_CNT : num_nbr;
  assign start_ok    = (state_q == S_IDLE) && start;
  assign ready_int   = (state_q == S_ACCUM) && (cnt_q < num_q);
  assign accept      = in_valid && ready_int;
  assign grad_prod   = s2_j_q * s2_sin_q;
  assign ham_prod    = s2_j_q * s2_cos_q;
  assign grad_sum    = sat_add(grad_q, grad_prod);
  assign ham_sum     = sat_add(ham_q, ham_prod);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_clamped == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = ready_int;
        if (accept && ((cnt_q + CNT_W'(1)) == num_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // S1 empty means the edge ahead performs the last accumulation.
        if (!s1_valid_q) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run setup: latch spin phase and clamped neighbour count, track accepted beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      self_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
    end else if (start_ok) begin
      self_q <= self_phase;
      num_q  <= num_clamped;
      cnt_q  <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Pipeline stages S1 (phase difference) and S2 (table lookup).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_delta_q <= '0;
      s1_j_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sin_q   <= '0;
      s2_cos_q   <= '0;
      s2_j_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_delta_q <= self_q - coupling_phase;
        s1_j_q     <= coupling_factor;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sin_q <= sin_lut[s1_delta_q];
        s2_cos_q <= cos_lut[s1_delta_q];
        s2_j_q   <= s1_j_q;
      end
    end
  end

  // Stage S3: saturating accumulation with a sticky clamp flag per run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grad_q <= '0;
      ham_q  <= '0;
      sat_q  <= 1'b0;
    end else if (start_ok) begin
      grad_q <= '0;
      ham_q  <= '0;
      sat_q  <= 1'b0;
    end else if (s2_valid_q) begin
      grad_q <= grad_sum[ACC_W-1:0];
      ham_q  <= ham_sum[ACC_W-1:0];
      sat_q  <= sat_q | grad_sum[ACC_W] | ham_sum[ACC_W];
    end
  end

  assign out_gradient    = grad_q;
  assign out_hamiltonian = ham_q;
  assign sat_flag        = sat_q;

endmodule
`default_nettype wire

// File: doc/multi_coupling_estimator.md
Name: multi_coupling_estimator

Overview:
- Parametrised successor to the single-pair in-PE estimator.
- Accepts one spin's self phase and then streams up to MAX_NBR (coupling phase, coupling factor) beats over a valid/ready handshake.
- Accumulates the coupling-weighted gradient J·sin(Δ) and Hamiltonian J·cos(Δ) over all beats, with saturation, and presents both totals on a held valid/ready output.
- Sits inside the PE between the phase memory and the phase-update logic.

Parameters:
PHASE_W, 8, phase word width; one full turn = 2^PHASE_W
NL_W, 12, signed width of internal sin/cos LUT samples
COUP_W, 8, signed coupling-factor width
MAX_NBR, 16, maximum neighbours per run
ACC_W, 28, signed accumulator/output width
CNT_W, $clog2(MAX_NBR+1), neighbour-count width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a run (honoured only in IDLE)
num_nbr  in  CNT_W  neighbours this run, sampled with start; values >MAX_NBR clamp to MAX_NBR
self_phase  in  PHASE_W  spin phase, sampled with start
in_valid  in  1  coupling beat valid
in_ready  out  1  coupling beat accepted
coupling_phase  in  PHASE_W  neighbour phase
coupling_factor  in  COUP_W  signed J
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
out_gradient  out  ACC_W  signed ΣJ·sin(Δ)
out_hamiltonian  out  ACC_W  signed ΣJ·cos(Δ)
sat_flag  out  1  an accumulator saturated during this run
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, asynchronous): state IDLE. All outputs and accumulators, the counter, pipeline valids, and latched phase/count are 0.
- Phase difference: Δ = (self_phase − coupling_phase) mod 2^PHASE_W (unsigned wrap).
- LUT contents are constant, generated at elaboration: round(sin/cos(2πΔ/2^PHASE_W)·(2^(NL_W−1)−1)). For defaults: sin(64)=2047, cos(0)=2047, cos(128)=−2047, sin(0)=sin(128)=0.
- Products are signed, COUP_W+NL_W bits, sign-extended to ACC_W+1 before the add. The sum clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. A clamp on either accumulator sets sat_flag (sticky until the next accepted start).
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: in_ready=0. On start, latch self_phase and clamped num_nbr, clear accumulators, sat_flag and beat counter.
    - Latched count 0: go straight to DONE; out_valid rises 1 edge after start with zero results.
    - Otherwise: go to ACCUM.
  - ACCUM: in_ready=1 while accepted count < latched count. Each in_valid&&in_ready edge increments the count and pushes the beat into the pipeline. Gaps in in_valid are allowed. On the edge accepting the last beat, go to DRAIN (in_ready=0 from the next cycle).
  - Pipeline: S1 registers Δ and J at the accept edge; S2 registers the LUT sin/cos; S3 multiplies and accumulates. Throughput is 1 beat/cycle.
  - J==0 beats are counted but add exactly 0.
  - DRAIN: wait until S1/S2/S3 are empty. Enter DONE on the edge performing the final accumulation, so out_valid rises 3 edges after the last handshake edge.
  - DONE: out_valid=1. out_gradient, out_hamiltonian and sat_flag are held stable until the out_valid&&out_ready edge, which returns to IDLE. Outputs keep their values after that; out_valid drops.
- start outside IDLE is ignored, including in DONE on the same cycle as the output handshake. in_valid outside ACCUM is ignored.
- Reset mid-run aborts immediately. Partial results are discarded and no out_valid is produced.

Test Plan:
1. start, num_nbr=0 -> out_valid on next edge; grad=0, H=0, sat_flag=0; out_ready=1 returns busy to 0.
2. self=64, one beat coupling=0, J=3 (defaults) -> out_valid 3 edges after handshake; grad=6141, H=0.
3. self=0, four beats (with idle in_valid gaps): (0,J=1),(128,J=1),(0,J=0),(64,J=−2) -> grad=4094, H=0, exactly 4 handshakes, then in_ready=0.
4. Wrap: self=0, coupling=192, J=1 -> Δ=64; grad=2047, H=0.
5. ACC_W=16, self=64, two beats coupling=0, J=127 -> grad=32767, sat_flag=1, H=0.
6. Hold out_ready=0 for 5 cycles in DONE while pulsing start -> outputs stable, no new run. Separately, assert reset low mid-ACCUM -> all outputs 0 immediately, state IDLE, no out_valid.
